// File: rtl/mmio_master_pkg.sv
// Shared definitions for the MMIO master: FSM encoding and the default ack timeout.
package mmio_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RESP
    } mm_state_e;

    localparam int unsigned ACK_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/mmio_master_parity.sv
// Parameterised parity generator: XOR of all data bits, inverted when odd parity is selected.
module mmio_master_parity #(
    parameter int unsigned BITS = 64
) (
    input  logic [0:BITS-1] data,
    input  logic            odd_parity,
    output logic            par
);

    assign par = (^data) ^ odd_parity;

endmodule

// File: rtl/mmio_master.sv
// Single-outstanding MMIO master: takes one command, issues it to the AFU, waits for the
// acknowledge (bounded by ACK_TIMEOUT) and returns a one-cycle completion.
module mmio_master
    import mmio_master_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        ha_pclock,
    input  logic        reset_n,
    input  logic        odd_parity,

    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_cfg,
    input  logic        req_rnw,
    input  logic        req_dw,
    input  logic [0:23] req_ad,
    input  logic [0:63] req_wdata,

    output logic        ha_mmval,
    output logic        ha_mmcfg,
    output logic        ha_mmrnw,
    output logic        ha_mmdw,
    output logic [0:23] ha_mmad,
    output logic        ha_mmadpar,
    output logic [0:63] ha_mmdata,
    output logic        ha_mmdatapar,

    input  logic        ah_mmack,
    input  logic [0:63] ah_mmdata,
    input  logic        ah_mmdatapar,

    output logic        rsp_val,
    output logic [0:63] rsp_rdata,
    output logic        rsp_perr,
    output logic        rsp_timeout,
    output logic        stray_ack
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;

    mm_state_e        state, state_nxt;
    logic             live;
    logic [CNT_W-1:0] wait_cnt;
    logic             expired;

    logic             cfg_q, rnw_q, dw_q;
    logic [0:23]      ad_q;
    logic [0:63]      wdata_q;
    logic [0:63]      cap_data;
    logic             cap_par;
    logic             chk_par;
    logic             timeout_q;
    logic             stray_q;

    assign expired   = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign stray_ack = stray_q;

    always_ff @(posedge ha_pclock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_rdy     = 1'b0;
        ha_mmval    = 1'b0;
        ha_mmcfg    = 1'b0;
        ha_mmrnw    = 1'b0;
        ha_mmdw     = 1'b0;
        ha_mmad     = '0;
        ha_mmdata   = '0;
        rsp_val     = 1'b0;
        rsp_rdata   = '0;
        rsp_perr    = 1'b0;
        rsp_timeout = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // live holds req_rdy low for the cycle right after a reset edge
                req_rdy = live;
                if (live && req_val) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                ha_mmval  = 1'b1;
                ha_mmcfg  = cfg_q;
                ha_mmrnw  = rnw_q;
                ha_mmdw   = dw_q;
                ha_mmad   = ad_q;
                ha_mmdata = wdata_q;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ah_mmack || expired) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_val     = 1'b1;
                rsp_timeout = timeout_q;
                if (!timeout_q && rnw_q) begin
                    rsp_rdata = dw_q ? cap_data : {32'h0, cap_data[32:63]};
                    rsp_perr  = (cap_par != chk_par);
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ha_pclock) begin
        if (!reset_n) begin
            live      <= 1'b0;
            wait_cnt  <= '0;
            stray_q   <= 1'b0;
            timeout_q <= 1'b0;
            cfg_q     <= 1'b0;
            rnw_q     <= 1'b0;
            dw_q      <= 1'b0;
            ad_q      <= '0;
            wdata_q   <= '0;
            cap_data  <= '0;
            cap_par   <= 1'b0;
        end else begin
            live    <= 1'b1;
            stray_q <= ah_mmack && (state != ST_WAIT_ACK);
            if (state == ST_IDLE && live && req_val) begin
                cfg_q     <= req_cfg;
                rnw_q     <= req_rnw;
                dw_q      <= req_dw;
                ad_q      <= req_ad;
                timeout_q <= 1'b0;
                // write data is stored already in bus format (32-bit writes replicated)
                if (req_rnw)     wdata_q <= '0;
                else if (req_dw) wdata_q <= req_wdata;
                else             wdata_q <= {req_wdata[32:63], req_wdata[32:63]};
            end
            if (state == ST_ISSUE) wait_cnt <= '0;
            if (state == ST_WAIT_ACK) begin
                if (ah_mmack) begin
                    cap_data <= ah_mmdata;
                    cap_par  <= ah_mmdatapar;
                end else if (expired) begin
                    timeout_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    mmio_master_parity #(.BITS(24)) u_adpar (
        .data       (ha_mmad),
        .odd_parity (odd_parity),
        .par        (ha_mmadpar)
    );

    mmio_master_parity #(.BITS(64)) u_datapar (
        .data       (ha_mmdata),
        .odd_parity (odd_parity),
        .par        (ha_mmdatapar)
    );

    mmio_master_parity #(.BITS(64)) u_chkpar (
        .data       (cap_data),
        .odd_parity (odd_parity),
        .par        (chk_par)
    );

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: reads, writes, parity error, timeout, stray ack, reset abort.
module tb_mmio_master;

    logic        ha_pclock = 1'b0;
    logic        reset_n;
    logic        odd_parity;
    logic        req_val, req_rdy, req_cfg, req_rnw, req_dw;
    logic [0:23] req_ad;
    logic [0:63] req_wdata;
    logic        ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmadpar, ha_mmdatapar;
    logic [0:23] ha_mmad;
    logic [0:63] ha_mmdata;
    logic        ah_mmack, ah_mmdatapar;
    logic [0:63] ah_mmdata;
    logic        rsp_val, rsp_perr, rsp_timeout, stray_ack;
    logic [0:63] rsp_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 ha_pclock = ~ha_pclock;

    mmio_master #(.ACK_TIMEOUT(16)) dut (
        .ha_pclock    (ha_pclock),
        .reset_n      (reset_n),
        .odd_parity   (odd_parity),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_cfg      (req_cfg),
        .req_rnw      (req_rnw),
        .req_dw       (req_dw),
        .req_ad       (req_ad),
        .req_wdata    (req_wdata),
        .ha_mmval     (ha_mmval),
        .ha_mmcfg     (ha_mmcfg),
        .ha_mmrnw     (ha_mmrnw),
        .ha_mmdw      (ha_mmdw),
        .ha_mmad      (ha_mmad),
        .ha_mmadpar   (ha_mmadpar),
        .ha_mmdata    (ha_mmdata),
        .ha_mmdatapar (ha_mmdatapar),
        .ah_mmack     (ah_mmack),
        .ah_mmdata    (ah_mmdata),
        .ah_mmdatapar (ah_mmdatapar),
        .rsp_val      (rsp_val),
        .rsp_rdata    (rsp_rdata),
        .rsp_perr     (rsp_perr),
        .rsp_timeout  (rsp_timeout),
        .stray_ack    (stray_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_par(input logic [63:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    task automatic cyc();
        @(negedge ha_pclock);
    endtask

    // Called in IDLE; returns at the first WAIT_ACK cycle (ISSUE+1).
    task automatic send(input logic cfg, input logic rnw, input logic dw, input logic [23:0] ad,
                        input logic [63:0] wd, input logic [63:0] exp_data);
        check("req_rdy", req_rdy, 1);
        req_cfg = cfg; req_rnw = rnw; req_dw = dw; req_ad = ad; req_wdata = wd;
        req_val = 1'b1;
        cyc();
        req_val = 1'b0;
        check("ha_mmval", ha_mmval, 1);
        check("ha_mmcfg", ha_mmcfg, cfg);
        check("ha_mmrnw", ha_mmrnw, rnw);
        check("ha_mmdw", ha_mmdw, dw);
        check("ha_mmad", ha_mmad, ad);
        check("ha_mmdata", ha_mmdata, exp_data);
        check("ha_mmadpar", ha_mmadpar, ref_par({40'h0, ad}, odd_parity));
        check("ha_mmdatapar", ha_mmdatapar, ref_par(exp_data, odd_parity));
        cyc();
        check("ha_mmval_drop", ha_mmval, 0);
        check("ha_mmdata_idle", ha_mmdata, 0);
    endtask

    // Asserts the ack during cycle ISSUE+dly (dly >= 1); returns in the RESP cycle.
    task automatic ack_after(input int unsigned dly, input logic [63:0] d, input logic bad_par);
        for (int unsigned i = 1; i < dly; i++) cyc();
        ah_mmack = 1'b1; ah_mmdata = d;
        ah_mmdatapar = ref_par(d, odd_parity) ^ bad_par;
        cyc();
        ah_mmack = 1'b0; ah_mmdata = '0; ah_mmdatapar = 1'b0;
    endtask

    task automatic expect_rsp(input logic [63:0] rd, input logic perr, input logic to);
        check("rsp_val", rsp_val, 1);
        check("rsp_rdata", rsp_rdata, rd);
        check("rsp_perr", rsp_perr, perr);
        check("rsp_timeout", rsp_timeout, to);
        check("no_stray", stray_ack, 0);
        cyc();
        check("rsp_val_pulse", rsp_val, 0);
        check("req_rdy_back", req_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; odd_parity = 1'b1;
        req_val = 1'b0; req_cfg = 1'b0; req_rnw = 1'b0; req_dw = 1'b0;
        req_ad = '0; req_wdata = '0;
        ah_mmack = 1'b0; ah_mmdata = '0; ah_mmdatapar = 1'b0;
        cyc(); cyc();
        check("rst_req_rdy", req_rdy, 0);
        check("rst_ha_mmval", ha_mmval, 0);
        check("rst_ha_mmadpar", ha_mmadpar, 1);
        check("rst_ha_mmdatapar", ha_mmdatapar, 1);
        check("rst_rsp_val", rsp_val, 0);
        check("rst_stray", stray_ack, 0);
        reset_n = 1'b1;
        cyc();
        check("rdy_after_release", req_rdy, 1);

        // cfg read, dw=1, ack 5 cycles after ISSUE
        send(1, 1, 1, 24'h000000, 64'h0, 64'h0);
        check("wait_no_rsp", rsp_val, 0);
        ack_after(5, 64'h0000000080000010, 0);
        expect_rsp(64'h0000000080000010, 0, 0);

        // 32-bit write: low word replicated on the bus
        send(0, 0, 0, 24'h000010, 64'h00000000DEADBEEF, 64'hDEADBEEFDEADBEEF);
        ack_after(2, 64'h0000000000001234, 0);
        expect_rsp(64'h0, 0, 0);

        // read with inverted read-data parity
        send(0, 1, 1, 24'h000004, 64'hFFFF_0000_1234_5678, 64'h0);
        ack_after(1, 64'hA5A5A5A5_5A5A5A5A, 1);
        expect_rsp(64'hA5A5A5A5_5A5A5A5A, 1, 0);

        // 32-bit read returns only the low word
        send(0, 1, 0, 24'h00ABCD, 64'h0, 64'h0);
        ack_after(3, 64'h11223344_55667788, 0);
        expect_rsp(64'h00000000_55667788, 0, 0);

        // 64-bit write; bad ack parity must not flag an error on a write
        send(0, 0, 1, 24'h800001, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
        ack_after(4, 64'hFFFFFFFF_FFFFFFFF, 1);
        expect_rsp(64'h0, 0, 0);

        // timeout after 16 WAIT_ACK cycles, then a late ack is stray
        send(0, 1, 1, 24'h000100, 64'h0, 64'h0);
        for (int unsigned i = 1; i < 16; i++) begin
            check("to_no_rsp", rsp_val, 0);
            cyc();
        end
        check("to_no_rsp_last", rsp_val, 0);
        cyc();
        expect_rsp(64'h0, 0, 1);
        cyc(); cyc();
        ah_mmack = 1'b1; ah_mmdata = 64'hCAFE;
        cyc();
        ah_mmack = 1'b0; ah_mmdata = '0;
        check("stray_ack", stray_ack, 1);
        check("stray_rsp_val", rsp_val, 0);
        check("stray_still_idle", req_rdy, 1);
        cyc();
        check("stray_pulse", stray_ack, 0);

        // ack arriving in the cycle the timeout expires wins
        send(0, 1, 1, 24'h000200, 64'h0, 64'h0);
        ack_after(16, 64'h00000000_0000BEEF, 0);
        expect_rsp(64'h00000000_0000BEEF, 0, 0);

        // reset during WAIT_ACK abandons the request; late ack is stray
        send(0, 1, 1, 24'h000300, 64'h0, 64'h0);
        cyc();
        reset_n = 1'b0;
        cyc();
        check("abort_rsp_val", rsp_val, 0);
        check("abort_req_rdy", req_rdy, 0);
        check("abort_ha_mmval", ha_mmval, 0);
        check("abort_ha_mmadpar", ha_mmadpar, 1);
        check("abort_rsp_timeout", rsp_timeout, 0);
        reset_n = 1'b1;
        ah_mmack = 1'b1; ah_mmdata = 64'h55;
        cyc();
        ah_mmack = 1'b0; ah_mmdata = '0;
        check("late_ack_stray", stray_ack, 1);
        check("late_ack_rsp_val", rsp_val, 0);
        check("abort_rdy_back", req_rdy, 1);
        send(1, 1, 1, 24'h000008, 64'h0, 64'h0);
        ack_after(2, 64'h0000000F_00000001, 0);
        expect_rsp(64'h0000000F_00000001, 0, 0);

        // odd_parity toggled: ad=0x000002 has one set bit
        odd_parity = 1'b0;
        cyc();
        check("even_idle_adpar", ha_mmadpar, 0);
        check("even_idle_datapar", ha_mmdatapar, 0);
        send(0, 1, 1, 24'h000002, 64'h0, 64'h0);
        ack_after(1, 64'h00000000_00000003, 0);
        expect_rsp(64'h00000000_00000003, 0, 0);
        odd_parity = 1'b1;
        cyc();
        check("odd_idle_adpar", ha_mmadpar, 1);
        send(0, 1, 1, 24'h000002, 64'h0, 64'h0);
        ack_after(1, 64'h00000000_00000007, 0);
        expect_rsp(64'h00000000_00000007, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
